// File: rtl/array_mem_pkg.sv
// Shared constants, FSM state type and zigzag scan table for array_to_mem.
// The zigzag table is only referenced when ARRAY_TO_MEM_ZIGZAG_EN is defined.
package array_mem_pkg;

  localparam int MAX_BLOCK_NUM = 32;
  localparam int MAX_PIXEL_NUM = 64;
  localparam int BLOCK_DIM     = 8;

  localparam int SLOT_W = $clog2(MAX_BLOCK_NUM);
  localparam int BEAT_W = $clog2(MAX_PIXEL_NUM);
  localparam int DIM_W  = $clog2(BLOCK_DIM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Raster position (row*8+col) visited at each zigzag step.
  localparam int ZZ_POS [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [DIM_W-1:0] zz_row(
    input logic [BEAT_W-1:0] n
  );
    return DIM_W'(ZZ_POS[n] / BLOCK_DIM);
  endfunction

  function automatic logic [DIM_W-1:0] zz_col(
    input logic [BEAT_W-1:0] n
  );
    return DIM_W'(ZZ_POS[n] % BLOCK_DIM);
  endfunction

endpackage

// File: rtl/array_to_mem_scan.sv
// Maps a beat index to the (row, col) of the captured block element.
// Raster by default; zigzag when ARRAY_TO_MEM_ZIGZAG_EN is defined.
module array_to_mem_scan
  import array_mem_pkg::*;
(
  input  logic [BEAT_W-1:0] beat,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col
);

`ifdef ARRAY_TO_MEM_ZIGZAG_EN
  assign row = zz_row(beat);
  assign col = zz_col(beat);
`else
  assign row = beat[BEAT_W-1:DIM_W];
  assign col = beat[DIM_W-1:0];
`endif

endmodule

// File: rtl/array_to_mem.sv
// Streams one captured 8x8 block to memory, one word per accepted beat.
// Scan order selected by ARRAY_TO_MEM_ZIGZAG_EN (raster when undefined).
module array_to_mem
  import array_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           counter,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][DATA_WIDTH-1:0]
                                input_data_array,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][DATA_WIDTH-1:0] cap_q;

  logic [SLOT_W-1:0] slot;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic              take;
  logic              accept;
  logic              last_beat;

  assign slot = SLOT_W'(counter % MAX_BLOCK_NUM);
  assign take = (state_q == ST_IDLE) && start;
  assign accept = (state_q == ST_WRITE) && mem_ready;
  assign last_beat = beat_q == BEAT_W'(MAX_PIXEL_NUM - 1);

  // Block sequencing and beat index advance on each accepted beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WRITE;
            beat_q  <= '0;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Snapshot block and slot base address so later input changes are harmless.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_q  <= '0;
      base_q <= '0;
    end else if (take) begin
      cap_q  <= input_data_array;
      base_q <= offset + (ADDR_WIDTH'(slot) << BEAT_W);
    end
  end

  array_to_mem_scan u_scan (
    .beat (beat_q),
    .row  (row),
    .col  (col)
  );

  assign mem_valid = state_q == ST_WRITE;
  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_DONE;
  assign mem_addr  = base_q + ADDR_WIDTH'(beat_q);
  assign mem_wdata = cap_q[row][col];

endmodule

// File: tb/tb_array_to_mem.sv
// Directed self-checking bench for array_to_mem.
// Expected data follows ARRAY_TO_MEM_ZIGZAG_EN when defined.
module tb_array_to_mem;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic [31:0] counter;
  logic [AW-1:0] offset;
  logic [7:0][7:0][DW-1:0] arr;
  logic mem_valid;
  logic mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic busy;
  logic done;

  int total = 0;
  int bad = 0;

  array_to_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .counter          (counter),
    .offset           (offset),
    .input_data_array (arr),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .busy             (busy),
    .done             (done)
  );

  always #5 clock = ~clock;

`ifdef ARRAY_TO_MEM_ZIGZAG_EN
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };
  function automatic logic [DW-1:0] exp_data(input int n);
    if (n < 0 || n > 63) return '1;
    return DW'(ZZ[n]);
  endfunction
`else
  function automatic logic [DW-1:0] exp_data(input int n);
    if (n < 0 || n > 63) return '1;
    return DW'(n);
  endfunction
`endif

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic fill_ramp;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        arr[r][c] = DW'(r * 8 + c);
  endtask

  task automatic fill_junk;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        arr[r][c] = 32'hDEAD_0000 | DW'(r * 8 + c + 100);
  endtask

  task automatic launch(input logic [31:0] cnt, input logic [AW-1:0] off);
    counter = cnt;
    offset = off;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    total++;
    if (mem_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", mem_valid);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", done);
    end
    total++;
    if (mem_addr !== '0) begin
      bad++; $display("FAIL reset_addr got=%h want=0", mem_addr);
    end
    total++;
    if (mem_wdata !== '0) begin
      bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset busy=%b valid=%b want 0 0", busy, mem_valid);
    end
  endtask

  task automatic test_raster;
    logic [AW-1:0] ea;
    fill_ramp();
    mem_ready = 1'b1;
    launch(32'd2, 32'h100);
    fill_junk();
    offset = 32'h55;
    counter = 32'd7;
    for (int n = 0; n < 64; n++) begin
      ea = 32'h180 + AW'(n);
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== ea || mem_wdata !== exp_data(n)) begin
        bad++;
        $display("FAIL raster beat %0d: valid=%b addr=%h data=%h want addr=%h data=%h",
                 n, mem_valid, mem_addr, mem_wdata, ea, exp_data(n));
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || mem_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL raster_done done=%b valid=%b busy=%b want 1 0 1", done, mem_valid, busy);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL raster_idle done=%b busy=%b want 0 0", done, busy);
    end
    fill_ramp();
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] base;
    int n;
    int done_at;
    base = 32'h1100;
    n = 0;
    done_at = -1;
    fill_ramp();
    launch(32'd4, 32'h1000);
    for (int cyc = 0; cyc < 100 && done_at < 0; cyc++) begin
      mem_ready = !(cyc >= 10 && cyc < 13);
      if (done === 1'b1) begin
        done_at = cyc;
      end else begin
        total++;
        if (mem_valid !== 1'b1 || mem_addr !== base + AW'(n) || mem_wdata !== exp_data(n)) begin
          bad++;
          $display("FAIL bp cycle %0d beat %0d: valid=%b addr=%h data=%h want addr=%h data=%h",
                   cyc, n, mem_valid, mem_addr, mem_wdata, base + AW'(n), exp_data(n));
        end
        if (mem_ready) n++;
        tick();
      end
    end
    mem_ready = 1'b1;
    total++;
    if (done_at != 67 || n != 64) begin
      bad++; $display("FAIL bp_done at=%0d beats=%0d want at=67 beats=64", done_at, n);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL bp_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_addr_wrap;
    logic [AW-1:0] ea;
    mem_ready = 1'b1;
    launch(32'd35, 32'hFFFF_FFF0);
    total++;
    if (mem_addr !== 32'h0000_00B0) begin
      bad++; $display("FAIL wrap_first addr=%h want=000000b0", mem_addr);
    end
    for (int n = 0; n < 64; n++) begin
      ea = 32'hB0 + AW'(n);
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== ea || mem_wdata !== exp_data(n)) begin
        bad++;
        $display("FAIL wrap beat %0d: addr=%h data=%h want addr=%h data=%h",
                 n, mem_addr, mem_wdata, ea, exp_data(n));
      end
      tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL wrap_done got=%b want=1", done);
    end
    tick();
  endtask

  task automatic test_counter_wrap;
    launch(32'd33, 32'h0);
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h40) begin
      bad++; $display("FAIL slot33 valid=%b addr=%h want 1 00000040", mem_valid, mem_addr);
    end
    for (int n = 0; n < 64; n++) tick();
    total++;
    if (done !== 1'b1 || mem_addr !== 32'h40) begin
      bad++; $display("FAIL slot33_done done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_start_ignored;
    logic [AW-1:0] ea;
    fill_ramp();
    launch(32'd0, 32'h200);
    for (int n = 0; n < 64; n++) begin
      if (n == 20) begin
        start = 1'b1;
        counter = 32'd9;
        offset = 32'h7000;
        fill_junk();
      end else begin
        start = 1'b0;
      end
      ea = 32'h200 + AW'(n);
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== ea || mem_wdata !== exp_data(n)) begin
        bad++;
        $display("FAIL ign beat %0d: valid=%b addr=%h data=%h want addr=%h data=%h",
                 n, mem_valid, mem_addr, mem_wdata, ea, exp_data(n));
      end
      tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL ign_done got=%b want=1", done);
    end
    start = 1'b1;
    counter = 32'd1;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL ign_after done=%b busy=%b valid=%b want 0 0 0", done, busy, mem_valid);
    end
    tick();
    total++;
    if (busy !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL ign_not_queued busy=%b valid=%b want 0 0", busy, mem_valid);
    end
    fill_ramp();
  endtask

  task automatic test_reset_mid;
    logic [AW-1:0] ea;
    int dones;
    fill_ramp();
    launch(32'd6, 32'h0);
    for (int n = 0; n < 30; n++) tick();
    total++;
    if (mem_addr !== 32'h180 + 32'd30) begin
      bad++; $display("FAIL mid_beat30 addr=%h want=0000019e", mem_addr);
    end
    reset = 1'b1;
    #1;
    total++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset valid=%b busy=%b done=%b want 0 0 0", mem_valid, busy, done);
    end
    tick();
    tick();
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL mid_no_done busy_or_done_cycles=%0d want=0", dones);
    end
    launch(32'd5, 32'h0);
    for (int n = 0; n < 64; n++) begin
      ea = 32'h140 + AW'(n);
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== ea || mem_wdata !== exp_data(n)) begin
        bad++;
        $display("FAIL restart beat %0d: valid=%b addr=%h data=%h want addr=%h data=%h",
                 n, mem_valid, mem_addr, mem_wdata, ea, exp_data(n));
      end
      tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL restart_done got=%b want=1", done);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    counter = '0;
    offset = '0;
    fill_ramp();
    test_reset();
    test_raster();
    test_backpressure();
    test_addr_wrap();
    test_counter_wrap();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
